// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier control path.
package mult_pkg;

    // Default operand width: one add/shift iteration per multiplier bit.
    localparam int WIDTH_DEF = 8;

    // State encodings, kept explicit so waveforms and netlists stay readable.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        ADD   = ST_ADD,
        SHIFT = ST_SHIFT,
        HOLD  = ST_HOLD
    } state_t;

    // True in the states that make up an active multiply (START through SHIFT).
    function automatic logic is_busy_state(input state_t st);
        logic busy;
        case (st)
            START:   busy = 1'b1;
            ADD:     busy = 1'b1;
            SHIFT:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Iteration counter for the multiply loop: counts 0..WIDTH-1 and flags the
// final iteration so the FSM can pick Sub over Add and leave the loop.
module mult_step_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, increment saturates at the last iteration.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mult_control.sv
// Control FSM for the signed shift-add multiplier. Turns level requests
// (Execute, ClearA_LoadB) into one fixed-length multiply per press and
// drives the per-cycle datapath enables. Enables are decoded from the state
// (plus M in ADD and ClearA_LoadB in IDLE) so they act in the same cycle.
module mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Execute,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_XA,
    output logic Ld_B,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    state_t state_q;
    state_t state_d;
    logic   cnt_clr_s;
    logic   cnt_inc_s;
    logic   cnt_last_s;

    mult_step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .clr_i   (cnt_clr_s),
        .inc_i   (cnt_inc_s),
        .last_o  (cnt_last_s)
    );

    // Next-state, counter control and datapath enables; reset forces all quiet.
    always_comb begin
        state_d   = state_q;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        Clr_XA    = 1'b0;
        Ld_B      = 1'b0;
        Add       = 1'b0;
        Sub       = 1'b0;
        Shift     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        if (!Reset_n) begin
            state_d   = IDLE;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // Execute outranks a concurrent load request.
                    if (Execute) begin
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                        Ld_B    = ClearA_LoadB;
                        Clr_XA  = ClearA_LoadB;
                    end
                end
                START: begin
                    Clr_XA    = 1'b1;
                    Busy      = is_busy_state(state_q);
                    cnt_clr_s = 1'b1;
                    state_d   = ADD;
                end
                ADD: begin
                    Busy = is_busy_state(state_q);
                    // The sign bit of the multiplier carries negative weight.
                    if (M) begin
                        if (cnt_last_s) begin
                            Sub = 1'b1;
                        end else begin
                            Add = 1'b1;
                        end
                    end else begin
                        Add = 1'b0;
                    end
                    state_d = SHIFT;
                end
                SHIFT: begin
                    Shift = 1'b1;
                    Busy  = is_busy_state(state_q);
                    if (cnt_last_s) begin
                        state_d = HOLD;
                    end else begin
                        cnt_inc_s = 1'b1;
                        state_d   = ADD;
                    end
                end
                HOLD: begin
                    Done = 1'b1;
                    // Wait for release so a held button yields one multiply.
                    if (!Execute) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control with a behavioural X:A:B datapath model.
module tb_mult_control;

    logic Clk = 1'b0;
    logic Reset_n, Execute, ClearA_LoadB, M;
    logic Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done;

    always #5 Clk = ~Clk;

    mult_control #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Execute      (Execute),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_XA       (Clr_XA),
        .Ld_B         (Ld_B),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done)
    );

    // Datapath model state and switch inputs.
    logic [7:0] sw = 8'h00;
    logic [7:0] s_val = 8'h00;
    logic       m_x = 1'b0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    assign M = m_b[0];

    // Enables sampled mid-cycle, applied at the following rising edge.
    logic       op_clr = 1'b0, op_ld = 1'b0, op_add = 1'b0, op_sub = 1'b0, op_shift = 1'b0;
    logic [7:0] op_sw = 8'h00, op_s = 8'h00;

    typedef struct {
        logic [15:0] prod;
        int          adds;
        int          subs;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int   run_starts = 0;
    int   n_busy = 0, n_shift = 0, n_add = 0, n_sub = 0, n_clr = 0, n_ld = 0;
    int   ld_total = 0;
    int   viol_cnt = 0;
    logic busy_prev = 1'b0, done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Datapath model update.
    always @(posedge Clk) begin
        if (op_clr) begin
            m_x <= 1'b0;
            m_a <= 8'h00;
        end
        if (op_ld) m_b <= op_sw;
        if (op_add) {m_x, m_a} <= {m_a[7], m_a} + {op_s[7], op_s};
        if (op_sub) {m_x, m_a} <= {m_a[7], m_a} - {op_s[7], op_s};
        if (op_shift) begin
            m_a <= {m_x, m_a[7:1]};
            m_b <= {m_a[0], m_b[7:1]};
        end
    end

    // Monitor: samples enables, tallies each run, checks on Done rising.
    always @(negedge Clk) begin
        op_clr   <= Clr_XA;
        op_ld    <= Ld_B;
        op_add   <= Add;
        op_sub   <= Sub;
        op_shift <= Shift;
        op_sw    <= sw;
        op_s     <= s_val;
        busy_prev <= Busy;
        done_prev <= Done;
        ld_total  <= ld_total + int'(Ld_B);
        if (($countones({Add, Sub, Shift, Clr_XA, Ld_B}) > 1) &&
            ({Add, Sub, Shift, Clr_XA, Ld_B} != 5'b00011))
            viol_cnt <= viol_cnt + 1;
        if (Busy && !busy_prev) begin
            run_starts <= run_starts + 1;
            n_busy  <= 1;
            n_shift <= int'(Shift);
            n_add   <= int'(Add);
            n_sub   <= int'(Sub);
            n_clr   <= int'(Clr_XA);
            n_ld    <= int'(Ld_B);
        end else if (Busy) begin
            n_busy  <= n_busy + 1;
            n_shift <= n_shift + int'(Shift);
            n_add   <= n_add + int'(Add);
            n_sub   <= n_sub + int'(Sub);
            n_clr   <= n_clr + int'(Clr_XA);
            n_ld    <= n_ld + int'(Ld_B);
        end
        if (Done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("sb_has_entry", sb.size(), 1);
            end else begin
                chk("product", {m_a, m_b}, sb[0].prod);
                chk("add_pulses", n_add, sb[0].adds);
                chk("sub_pulses", n_sub, sb[0].subs);
                chk("busy_cycles", n_busy, 17);
                chk("shift_pulses", n_shift, 8);
                chk("clr_pulses", n_clr, 1);
                chk("ldb_in_run", n_ld, 0);
                sb.delete(0);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] v, input bit chk_en);
        sw = v;
        ClearA_LoadB = 1'b1;
        @(negedge Clk);
        if (chk_en) begin
            chk("load_ldb", Ld_B, 1'b1);
            chk("load_clr", Clr_XA, 1'b1);
            chk("load_busy", Busy, 1'b0);
        end
        step();
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        if (chk_en) chk("load_one_cycle", {Ld_B, Clr_XA}, 2'b00);
        step();
    endtask

    task automatic run_until_done();
        bit found = 1'b0;
        Execute = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (Done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("run_done_seen", found, 1'b1);
        Execute = 1'b0;
        ClearA_LoadB = 1'b0;
        step();
        step();
    endtask

    initial begin
        int bc;
        int snap;
        exp_t e;
        Reset_n = 1'b0;
        Execute = 1'b1;
        ClearA_LoadB = 1'b0;

        // Reset with Execute held: everything quiet.
        @(negedge Clk);
        chk("rst_outputs_0", {Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}, 7'b0);
        step();
        @(negedge Clk);
        chk("rst_outputs_1", {Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}, 7'b0);
        step();
        Reset_n = 1'b1;
        Execute = 1'b0;
        @(negedge Clk);
        chk("rst_release_idle", {Busy, Done}, 2'b00);
        step();
        @(negedge Clk);
        chk("idle_stays", {Busy, Done}, 2'b00);
        step();

        // Single-cycle load, then full run 0xC5 * 0x07 with Execute held 30 cycles.
        s_val = 8'h07;
        load_b(8'hC5, 1'b1);
        e.prod = 16'hFE63; e.adds = 3; e.subs = 1;
        sb.push_back(e);
        Execute = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ClearA_LoadB = ((i >= 5 && i <= 7) || (i >= 25 && i <= 27));
            sw = 8'h55;
            if (i == 26) begin
                @(negedge Clk);
                chk("hold_ignores_load", {Ld_B, Clr_XA}, 2'b00);
            end
            step();
        end
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        chk("done_held", {Done, Busy}, 2'b10);
        Execute = 1'b0;
        step();
        @(negedge Clk);
        chk("idle_after_release", {Busy, Done}, 2'b00);
        step();

        // Sign correction: -1 * -1.
        s_val = 8'hFF;
        load_b(8'hFF, 1'b0);
        e.prod = 16'h0001; e.adds = 7; e.subs = 1;
        sb.push_back(e);
        run_until_done();

        // Zero multiplier: no Add/Sub, same latency.
        s_val = 8'h07;
        load_b(8'h00, 1'b0);
        e.prod = 16'h0000; e.adds = 0; e.subs = 0;
        sb.push_back(e);
        run_until_done();

        // Reset in the 9th Busy cycle, then a clean rerun.
        s_val = 8'hFF;
        load_b(8'hFF, 1'b0);
        Execute = 1'b1;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Busy) bc++;
            if (bc == 9) break;
        end
        chk("reached_busy9", bc, 9);
        Reset_n = 1'b0;
        Execute = 1'b0;
        @(negedge Clk);
        chk("midrst_outputs", {Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}, 7'b0);
        step();
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("midrst_idle", {Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}, 7'b0);
        step();
        load_b(8'hFF, 1'b0);
        e.prod = 16'h0001; e.adds = 7; e.subs = 1;
        sb.push_back(e);
        run_until_done();

        // Execute and ClearA_LoadB together: run wins, B untouched.
        s_val = 8'h07;
        load_b(8'hC5, 1'b0);
        sw = 8'h12;
        snap = ld_total;
        e.prod = 16'hFE63; e.adds = 3; e.subs = 1;
        sb.push_back(e);
        Execute = 1'b1;
        ClearA_LoadB = 1'b1;
        @(negedge Clk);
        chk("simul_no_ldb", Ld_B, 1'b0);
        run_until_done();
        chk("simul_ld_total", ld_total - snap, 0);

        // Re-press: B = 0x63 (previous low byte) times 0x07.
        e.prod = 16'h02B5; e.adds = 4; e.subs = 0;
        sb.push_back(e);
        run_until_done();

        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        chk("run_starts", run_starts, 7);
        chk("excl_viol", viol_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
